// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared constants and types for the MIPS fetch stage
package cpu_defs;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;

   localparam logic [1:0]  REDIR_BR = 2'd0;
   localparam logic [1:0]  REDIR_J  = 2'd1;
   localparam logic [1:0]  REDIR_JR = 2'd2;

   localparam logic [31:0] NOP = 32'h0;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;
endpackage

// File: rtl/ifu.sv
// rtl/ifu.sv - PC+4 incrementer for the fetch stage
module ifu (
   input  logic [31:0] i_pc,
   output logic [31:0] o_pc4
);
   assign o_pc4 = i_pc + 32'd4;
endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage controller: PC register, next-PC select, IF/ID register, fault halt
module fetch_ctrl
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
   parameter int          IM_AW    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_d,
   input  logic             redirect_valid,
   input  logic [1:0]       redirect_kind,
   input  logic [25:0]      imm26,
   input  logic [31:0]      rs_value,
   output logic [IM_AW-1:0] imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      pc_f,
   output logic [31:0]      instr_d,
   output logic [31:0]      pc_d,
   output logic [31:0]      pc8_d,
   output logic             valid_d,
   output logic             halted,
   output logic [31:0]      fault_pc,
   output logic [31:0]      fetch_count
);
   localparam logic [32:0] IM_BYTES = 33'd4 << IM_AW;

   fetch_state_t r_state;
   logic [31:0]  r_pc_f, r_instr_d, r_pc_d, r_pc8_d, r_fault_pc, r_fetch_count;
   logic         r_valid_d, r_halted;

   logic [31:0]  w_seq, w_pc_off, w_br_tgt, w_target, w_tgt_off;
   logic         w_legal, w_unused;

   ifu u_ifu (
      .i_pc  (r_pc_f),
      .o_pc4 (w_seq)
   );

   assign w_pc_off  = r_pc_f - IM_BASE;
   assign imem_addr = w_pc_off[IM_AW+1:2];
   assign w_unused  = ^{w_pc_off[1:0], w_pc_off[31:IM_AW+2]};

   assign w_br_tgt = r_pc_d + 32'd4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};

   always_comb begin
      w_target = w_seq;
      if (redirect_valid) begin
         case (redirect_kind)
            REDIR_J:  w_target = {r_pc_d[31:28], imm26, 2'b00};
            REDIR_JR: w_target = rs_value;
            default:  w_target = w_br_tgt;
         endcase
      end
   end

   // Offset compare keeps the upper bound correct even if the window touches 2^32.
   assign w_tgt_off = w_target - IM_BASE;
   assign w_legal   = (w_target[1:0] == 2'b00) && (w_target >= IM_BASE) &&
                      ({1'b0, w_tgt_off} < IM_BYTES);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_RUN;
         r_pc_f        <= RESET_PC;
         r_instr_d     <= NOP;
         r_pc_d        <= 32'd0;
         r_pc8_d       <= 32'd8;
         r_valid_d     <= 1'b0;
         r_halted      <= 1'b0;
         r_fault_pc    <= 32'd0;
         r_fetch_count <= 32'd0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (!stall_d) begin
                  // The current word is accepted even when the next target faults.
                  r_instr_d     <= imem_rdata;
                  r_pc_d        <= r_pc_f;
                  r_pc8_d       <= r_pc_f + 32'd8;
                  r_valid_d     <= 1'b1;
                  r_fetch_count <= r_fetch_count + 32'd1;
                  if (w_legal) begin
                     r_pc_f <= w_target;
                  end else begin
                     r_state    <= ST_HALT;
                     r_halted   <= 1'b1;
                     r_fault_pc <= w_target;
                  end
               end
            end
            ST_HALT: begin
               r_instr_d <= NOP;
               r_valid_d <= 1'b0;
            end
            default: r_state <= ST_HALT;
         endcase
      end
   end

   assign pc_f        = r_pc_f;
   assign instr_d     = r_instr_d;
   assign pc_d        = r_pc_d;
   assign pc8_d       = r_pc8_d;
   assign valid_d     = r_valid_d;
   assign halted      = r_halted;
   assign fault_pc    = r_fault_pc;
   assign fetch_count = r_fetch_count;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
   localparam logic [31:0] BASE = 32'h0000_3000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, stall_d, redirect_valid;
   logic [1:0]  redirect_kind;
   logic [25:0] imm26;
   logic [31:0] rs_value;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata, pc_f, instr_d, pc_d, pc8_d, fault_pc, fetch_count;
   logic        valid_d, halted;
   logic [31:0] mem [0:1023];
   assign imem_rdata = mem[imem_addr];

   logic        reset2;
   logic [1:0]  imem_addr2;
   logic [31:0] imem_rdata2, pc_f2, instr_d2, pc_d2, pc8_d2, fault_pc2, fetch_count2;
   logic        valid_d2, halted2;
   logic [31:0] mem2 [0:3];
   assign imem_rdata2 = mem2[imem_addr2];

   fetch_ctrl dut (
      .clk(clk), .reset(reset), .stall_d(stall_d), .redirect_valid(redirect_valid),
      .redirect_kind(redirect_kind), .imm26(imm26), .rs_value(rs_value),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_f(pc_f), .instr_d(instr_d),
      .pc_d(pc_d), .pc8_d(pc8_d), .valid_d(valid_d), .halted(halted),
      .fault_pc(fault_pc), .fetch_count(fetch_count)
   );

   fetch_ctrl #(.IM_AW(2)) dut2 (
      .clk(clk), .reset(reset2), .stall_d(1'b0), .redirect_valid(1'b0),
      .redirect_kind(2'd0), .imm26(26'd0), .rs_value(32'd0),
      .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .pc_f(pc_f2), .instr_d(instr_d2),
      .pc_d(pc_d2), .pc8_d(pc8_d2), .valid_d(valid_d2), .halted(halted2),
      .fault_pc(fault_pc2), .fetch_count(fetch_count2)
   );

   int passed = 0;
   int total  = 0;

   logic [31:0] m_pc, m_instr, m_pcd, m_fault, m_cnt;
   logic        m_valid, m_halt;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit legal_addr(input logic [31:0] t);
      longint unsigned a = t;
      return (a % 4 == 0) && (a >= BASE) && (a < longint'(BASE) + 4 * 1024);
   endfunction

   // Reference: what the spec says one clock edge does to the architectural state.
   task automatic model_step();
      logic [31:0] tgt;
      int          off;
      if (reset) begin
         m_pc = BASE; m_instr = 0; m_pcd = 0; m_valid = 0;
         m_halt = 0; m_fault = 0; m_cnt = 0;
      end else if (m_halt) begin
         m_instr = 0; m_valid = 0;
      end else if (!stall_d) begin
         tgt = m_pc + 4;
         if (redirect_valid) begin
            if (redirect_kind == 2'd1)      tgt = {m_pcd[31:28], imm26, 2'b00};
            else if (redirect_kind == 2'd2) tgt = rs_value;
            else begin
               off = int'($signed(imm26[15:0]));
               tgt = m_pcd + 32'd4 + 32'(off * 4);
            end
         end
         m_instr = mem[(m_pc - BASE) / 4];
         m_pcd   = m_pc;
         m_valid = 1;
         m_cnt   = m_cnt + 1;
         if (legal_addr(tgt)) m_pc = tgt;
         else begin
            m_halt = 1; m_fault = tgt;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1; stall_d = 0; redirect_valid = 0; redirect_kind = 0; imm26 = 0; rs_value = 0;
      tick(); tick();
      total++; if (pc_f !== 32'h3000) $display("FAIL reset_pc_f got %h exp 00003000", pc_f); else passed++;
      total++; if ({instr_d, pc_d, pc8_d} !== {32'h0, 32'h0, 32'h8})
         $display("FAIL reset_ifid got %h/%h/%h exp 0/0/8", instr_d, pc_d, pc8_d); else passed++;
      total++; if ({valid_d, halted, fault_pc, fetch_count, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 10'h0})
         $display("FAIL reset_status got v=%b h=%b f=%h c=%h a=%h", valid_d, halted, fault_pc, fetch_count, imem_addr);
      else passed++;
   endtask

   task automatic test_sequential();
      reset = 0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         total++; if (pc_f !== BASE + 32'(4 * i)) $display("FAIL seq_pc_f got %h exp %h", pc_f, BASE + 32'(4 * i)); else passed++;
      end
      total++; if ({pc_d, pc8_d, valid_d, fetch_count} !== {32'h3008, 32'h3010, 1'b1, 32'd3})
         $display("FAIL seq_ifid got pc_d=%h pc8=%h v=%b c=%0d exp 3008/3010/1/3", pc_d, pc8_d, valid_d, fetch_count);
      else passed++;
      total++; if (instr_d !== mem[2]) $display("FAIL seq_instr got %h exp %h", instr_d, mem[2]); else passed++;
      total++; if (imem_addr !== 10'd3) $display("FAIL seq_imem_addr got %h exp 3", imem_addr); else passed++;
   endtask

   task automatic test_branch();
      tick(); tick();
      redirect_valid = 1; redirect_kind = 2'd0; imm26 = 26'h000FFFC;
      tick();
      redirect_valid = 0;
      total++; if (pc_f !== 32'h3004) $display("FAIL branch_pc_f got %h exp 00003004", pc_f); else passed++;
      total++; if ({pc_d, valid_d, instr_d} !== {32'h3014, 1'b1, mem[5]})
         $display("FAIL branch_delay_slot got pc_d=%h v=%b i=%h exp 3014/1/%h", pc_d, valid_d, instr_d, mem[5]);
      else passed++;
   endtask

   task automatic test_jump();
      for (int i = 0; i < 8; i++) tick();
      total++; if (pc_d !== 32'h3020) $display("FAIL jump_setup got pc_d=%h exp 00003020", pc_d); else passed++;
      redirect_valid = 1; redirect_kind = 2'd1; imm26 = 26'h0000C05;
      tick();
      redirect_valid = 0;
      total++; if ({pc_f, fetch_count} !== {32'h3014, 32'd15})
         $display("FAIL jump_pc_f got %h c=%0d exp 00003014 c=15", pc_f, fetch_count); else passed++;
   endtask

   task automatic test_stall();
      stall_d = 1; redirect_valid = 1; redirect_kind = 2'd2; rs_value = 32'h3100;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if ({pc_f, instr_d, fetch_count} !== {32'h3014, mem[9], 32'd15})
            $display("FAIL stall_hold got pc=%h i=%h c=%0d exp 3014/%h/15", pc_f, instr_d, fetch_count, mem[9]);
         else passed++;
      end
      stall_d = 0;
      tick();
      redirect_valid = 0;
      total++; if ({pc_f, fetch_count} !== {32'h3100, 32'd16})
         $display("FAIL stall_release got pc=%h c=%0d exp 3100/16", pc_f, fetch_count); else passed++;
   endtask

   task automatic test_jr_fault();
      redirect_valid = 1; redirect_kind = 2'd2; rs_value = 32'h3002;
      tick();
      total++; if ({halted, fault_pc, pc_f} !== {1'b1, 32'h3002, 32'h3100})
         $display("FAIL jr_fault got h=%b f=%h pc=%h exp 1/3002/3100", halted, fault_pc, pc_f); else passed++;
      total++; if ({valid_d, pc_d, instr_d, fetch_count} !== {1'b1, 32'h3100, mem[64], 32'd17})
         $display("FAIL jr_fault_accept got v=%b pc_d=%h i=%h c=%0d", valid_d, pc_d, instr_d, fetch_count); else passed++;
      rs_value = 32'h3200;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if ({valid_d, instr_d, pc_f, fault_pc, fetch_count} !== {1'b0, 32'h0, 32'h3100, 32'h3002, 32'd17})
            $display("FAIL halt_bubble got v=%b i=%h pc=%h f=%h c=%0d", valid_d, instr_d, pc_f, fault_pc, fetch_count);
         else passed++;
      end
      redirect_valid = 0; reset = 1;
      tick();
      reset = 0;
      total++; if ({pc_f, halted, fetch_count} !== {32'h3000, 1'b0, 32'd0})
         $display("FAIL halt_reset got pc=%h h=%b c=%0d exp 3000/0/0", pc_f, halted, fetch_count); else passed++;
   endtask

   task automatic test_small_mem();
      reset2 = 0;
      for (int i = 0; i < 4; i++) tick();
      total++; if ({halted2, fault_pc2, fetch_count2, pc_f2} !== {1'b1, 32'h3010, 32'd4, 32'h300C})
         $display("FAIL runoff got h=%b f=%h c=%0d pc=%h exp 1/3010/4/300c", halted2, fault_pc2, fetch_count2, pc_f2);
      else passed++;
      total++; if ({instr_d2, pc_d2, valid_d2} !== {mem2[3], 32'h300C, 1'b1})
         $display("FAIL runoff_last got i=%h pc_d=%h v=%b", instr_d2, pc_d2, valid_d2); else passed++;
   endtask

   task automatic test_random();
      logic [235:0] exp_v, act_v;
      reset = 1; stall_d = 0; redirect_valid = 0;
      model_step(); tick();
      reset = 0;
      for (int n = 0; n < 800; n++) begin
         reset          = (m_halt && ($urandom % 4 == 0)) || ($urandom % 100 == 0);
         stall_d        = ($urandom % 4 == 0);
         redirect_valid = ($urandom % 3 == 0);
         redirect_kind  = 2'($urandom % 4);
         imm26          = 26'(32'hC00 + $urandom_range(0, 1023));
         if ($urandom % 10 == 0) imm26 = 26'($urandom);
         if (redirect_kind != 2'd1) imm26[15:0] = 16'(($urandom_range(0, 128) - 64));
         rs_value = BASE + 32'(4 * $urandom_range(0, 1023));
         if ($urandom % 8 == 0) rs_value = rs_value + 32'($urandom_range(1, 3));
         if ($urandom % 16 == 0) rs_value = BASE + 32'h1000;
         model_step();
         tick();
         exp_v = {m_pc, m_instr, m_pcd, m_pcd + 32'd8, m_valid, m_halt, m_fault, m_cnt, 10'((m_pc - BASE) / 4)};
         act_v = {pc_f, instr_d, pc_d, pc8_d, valid_d, halted, fault_pc, fetch_count, imem_addr};
         total++;
         if (act_v !== exp_v) $display("FAIL random[%0d] got %h exp %h", n, act_v, exp_v);
         else passed++;
      end
      reset = 0; stall_d = 0; redirect_valid = 0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem2[i] = $urandom;
      reset2 = 1;
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_stall();
      test_jr_fault();
      test_small_mem();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
